// File: rtl/mesh_term_rx.sv
// mesh_term_rx: receive terminal for one mesh node.
// Pops packets from the mesh terminal output, filters them by destination ID,
// and buffers matching packets in a local FIFO for a valid/ready consumer.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   pndng_i, data_out_i  mesh terminal: packet pending / head packet
//   pop_o                one-cycle pop pulse back to the mesh terminal
//   rd_valid_o/rd_data_o local FIFO head, advanced by rd_ready_i
//   fifo_count_o         local FIFO occupancy
//   rx_count_o           accepted packets (saturating)
//   misroute_count_o     dropped misaddressed packets (saturating)
//   rd_ts_o              accept-cycle timestamp of head entry
//                        (only when MESH_TERM_RX_TIMESTAMP_EN is defined)
module mesh_term_rx #(
  parameter int unsigned PAKG_SIZE = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROW_ID    = 0,
  parameter int unsigned COL_ID    = 0,
  parameter logic [7:0]  BDCST     = 8'hFF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pndng_i,
  input  logic [PAKG_SIZE-1:0]   data_out_i,
  output logic                   pop_o,
  output logic                   rd_valid_o,
  output logic [PAKG_SIZE-1:0]   rd_data_o,
  input  logic                   rd_ready_i,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic [15:0]            rx_count_o,
  output logic [15:0]            misroute_count_o
`ifdef MESH_TERM_RX_TIMESTAMP_EN
  ,
  output logic [31:0]            rd_ts_o
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [7:0]  MY_ID = {4'(ROW_ID), 4'(COL_ID)};

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t            state_q, state_d;
  logic              pop_q, pop_d;
  logic              armed_q, armed_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       rx_q, rx_d;
  logic [15:0]       mis_q, mis_d;
  logic [PAKG_SIZE-1:0] mem_q [DEPTH];

  logic [7:0] pkt_id;
  logic       hit, accept, wr_en, rd_en;

`ifdef MESH_TERM_RX_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  logic [31:0] ts_mem_q [DEPTH];
`endif

  always_comb begin
    pkt_id = data_out_i[PAKG_SIZE-9 -: 8];
    hit    = (pkt_id == MY_ID) || (pkt_id == BDCST);
    // armed_q holds off acceptance for the first edge after reset release.
    // Fullness uses the registered count, so a read on the same edge does
    // not make room for that edge's accept.
    accept = (state_q == IDLE) && armed_q && pndng_i && (count_q < CW'(DEPTH));
    wr_en  = accept && hit;
    rd_en  = (count_q != '0) && rd_ready_i;

    state_d  = IDLE;
    pop_d    = 1'b0;
    armed_d  = 1'b1;
    case (state_q)
      IDLE:    if (accept) begin
                 state_d = SETTLE;
                 pop_d   = 1'b1;
               end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);

    rx_d  = rx_q;
    mis_d = mis_q;
    if (wr_en && (rx_q != '1))
      rx_d = rx_q + 16'd1;
    if (accept && !hit && (mis_q != '1))
      mis_d = mis_q + 16'd1;

`ifdef MESH_TERM_RX_TIMESTAMP_EN
    ts_d = ts_q + 32'd1;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pop_q    <= 1'b0;
      armed_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rx_q     <= '0;
      mis_q    <= '0;
`ifdef MESH_TERM_RX_TIMESTAMP_EN
      ts_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pop_q    <= pop_d;
      armed_q  <= armed_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rx_q     <= rx_d;
      mis_q    <= mis_d;
`ifdef MESH_TERM_RX_TIMESTAMP_EN
      ts_q     <= ts_d;
`endif
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q]    <= data_out_i;
`ifdef MESH_TERM_RX_TIMESTAMP_EN
      ts_mem_q[wr_ptr_q] <= ts_q;
`endif
    end
  end

  assign pop_o            = pop_q;
  assign rd_valid_o       = (count_q != '0);
  assign rd_data_o        = mem_q[rd_ptr_q];
  assign fifo_count_o     = count_q;
  assign rx_count_o       = rx_q;
  assign misroute_count_o = mis_q;
`ifdef MESH_TERM_RX_TIMESTAMP_EN
  assign rd_ts_o          = ts_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_mesh_term_rx.sv
// tb_mesh_term_rx: directed self-checking bench for mesh_term_rx
// (ROW_ID=1, COL_ID=2, DEPTH=4, PAKG_SIZE=32). A small source model plays
// the mesh terminal: it presents queued packets and advances on pop_o.
module tb_mesh_term_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pndng_i;
  logic [31:0] data_out_i;
  logic        pop_o;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        rd_ready_i = 1'b0;
  logic [2:0]  fifo_count_o;
  logic [15:0] rx_count_o;
  logic [15:0] misroute_count_o;
`ifdef MESH_TERM_RX_TIMESTAMP_EN
  logic [31:0] rd_ts_o;
`endif

  mesh_term_rx #(
    .PAKG_SIZE(32),
    .DEPTH(4),
    .ROW_ID(1),
    .COL_ID(2),
    .BDCST(8'hFF)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .pndng_i(pndng_i),
    .data_out_i(data_out_i),
    .pop_o(pop_o),
    .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o),
    .rd_ready_i(rd_ready_i),
    .fifo_count_o(fifo_count_o),
    .rx_count_o(rx_count_o),
    .misroute_count_o(misroute_count_o)
`ifdef MESH_TERM_RX_TIMESTAMP_EN
    ,
    .rd_ts_o(rd_ts_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Source model
  logic [31:0] src_mem [256];
  int src_i = 0;
  int src_n = 0;
  assign pndng_i    = (src_i != src_n);
  assign data_out_i = src_mem[src_i[7:0]];

  // Monitor
  int cyc = 0;
  int pop_cnt = 0;
  int dbl_pop = 0;
  logic pop_prev = 1'b0;
  int pop_times[$];
  logic [31:0] got[$];

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (pop_o) begin
      pop_cnt <= pop_cnt + 1;
      pop_times.push_back(cyc);
    end
    if (pop_o && pop_prev) dbl_pop <= dbl_pop + 1;
    pop_prev <= pop_o;
    if (rd_valid_o && rd_ready_i) got.push_back(rd_data_o);
    if (pop_o && (src_i != src_n)) src_i <= src_i + 1;
  end

  function automatic logic [31:0] pkt(input logic [7:0] id, input logic [15:0] pl);
    return {8'hA5, id, pl};
  endfunction

  task automatic push(input logic [31:0] p);
    src_mem[src_n[7:0]] = p;
    src_n = src_n + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_got(input int n, input int limit);
    int k = 0;
    while (got.size() < n && k < limit) begin
      cycles(1);
      k++;
    end
  endtask

  // Assert reset, drop pending source packets, release at a falling edge.
  task automatic do_reset();
    rst_ni = 1'b0;
    rd_ready_i = 1'b0;
    #1;
    src_n = src_i;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    rd_ready_i = 1'b1;
    #1;
    src_n = src_i;
    push(pkt(8'h12, 16'h0001));
    @(negedge clk_i);
    total++; if (pop_o !== 1'b0) begin bad++; $display("FAIL rst_pop got=%b exp=0", pop_o); end
    total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rd_valid_o); end
    total++; if (fifo_count_o !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count_o); end
    total++; if (rx_count_o !== 16'd0 || misroute_count_o !== 16'd0) begin
      bad++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", rx_count_o, misroute_count_o); end
    rst_ni = 1'b1;
    cycles(1);
    total++; if (pop_o !== 1'b0) begin bad++; $display("FAIL first_edge_pop got=%b exp=0", pop_o); end
    cycles(1);
    total++; if (pop_o !== 1'b1) begin bad++; $display("FAIL second_edge_pop got=%b exp=1", pop_o); end
    cycles(4);
    total++; if (rx_count_o !== 16'd1) begin bad++; $display("FAIL rst_rx got=%0d exp=1", rx_count_o); end
  endtask

  task automatic test_stream();
    int gb, pb, tb0;
    do_reset();
    rd_ready_i = 1'b1;
    gb = got.size(); pb = pop_cnt; tb0 = pop_times.size();
    for (int i = 0; i < 6; i++) push(pkt(8'h12, 16'h0100 + 16'(i)));
    wait_got(gb + 6, 40);
    cycles(2);
    total++; if (got.size() - gb !== 6) begin bad++; $display("FAIL stream_n got=%0d exp=6", got.size() - gb); end
    for (int i = 0; i < 6 && gb + i < got.size(); i++) begin
      total++; if (got[gb+i] !== pkt(8'h12, 16'h0100 + 16'(i))) begin
        bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got[gb+i], pkt(8'h12, 16'h0100 + 16'(i))); end
    end
    total++; if (pop_cnt - pb !== 6) begin bad++; $display("FAIL stream_pops got=%0d exp=6", pop_cnt - pb); end
    for (int i = tb0 + 1; i < pop_times.size(); i++) begin
      total++; if (pop_times[i] - pop_times[i-1] !== 2) begin
        bad++; $display("FAIL stream_spacing got=%0d exp=2", pop_times[i] - pop_times[i-1]); end
    end
    total++; if (rx_count_o !== 16'd6) begin bad++; $display("FAIL stream_rx got=%0d exp=6", rx_count_o); end
  endtask

  task automatic test_misroute();
    int gb, pb;
    do_reset();
    rd_ready_i = 1'b1;
    gb = got.size(); pb = pop_cnt;
    push(pkt(8'h33, 16'hBEEF));
    cycles(8);
    total++; if (pop_cnt - pb !== 1) begin bad++; $display("FAIL mis_pops got=%0d exp=1", pop_cnt - pb); end
    total++; if (got.size() - gb !== 0) begin bad++; $display("FAIL mis_delivered got=%0d exp=0", got.size() - gb); end
    total++; if (rd_valid_o !== 1'b0) begin bad++; $display("FAIL mis_valid got=%b exp=0", rd_valid_o); end
    total++; if (misroute_count_o !== 16'd1) begin bad++; $display("FAIL mis_count got=%0d exp=1", misroute_count_o); end
    total++; if (rx_count_o !== 16'd0) begin bad++; $display("FAIL mis_rx got=%0d exp=0", rx_count_o); end
  endtask

  task automatic test_broadcast();
    int gb;
    do_reset();
    rd_ready_i = 1'b1;
    gb = got.size();
    push(pkt(8'hFF, 16'h5A5A));
    wait_got(gb + 1, 20);
    cycles(1);
    total++; if (rx_count_o !== 16'd1) begin bad++; $display("FAIL bc_rx got=%0d exp=1", rx_count_o); end
    total++; if (got.size() - gb !== 1) begin
      bad++; $display("FAIL bc_n got=%0d exp=1", got.size() - gb);
    end else if (got[gb] !== pkt(8'hFF, 16'h5A5A)) begin
      bad++; $display("FAIL bc_data got=%h exp=%h", got[gb], pkt(8'hFF, 16'h5A5A));
    end
  endtask

  task automatic test_full();
    int gb, pb;
    do_reset();
    gb = got.size(); pb = pop_cnt;
    for (int i = 0; i < 6; i++) push(pkt(8'h12, 16'h0200 + 16'(i)));
    cycles(20);
    total++; if (pop_cnt - pb !== 4) begin bad++; $display("FAIL full_pops got=%0d exp=4", pop_cnt - pb); end
    total++; if (pop_o !== 1'b0) begin bad++; $display("FAIL full_pop got=%b exp=0", pop_o); end
    total++; if (fifo_count_o !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", fifo_count_o); end
    total++; if (rd_data_o !== pkt(8'h12, 16'h0200)) begin
      bad++; $display("FAIL full_head got=%h exp=%h", rd_data_o, pkt(8'h12, 16'h0200)); end
    rd_ready_i = 1'b1;
    cycles(1);
    total++; if (pop_o !== 1'b0 || fifo_count_o !== 3'd3) begin
      bad++; $display("FAIL full_same_edge got=pop%b/cnt%0d exp=pop0/cnt3", pop_o, fifo_count_o); end
    cycles(1);
    total++; if (pop_o !== 1'b1 || fifo_count_o !== 3'd3) begin
      bad++; $display("FAIL full_resume got=pop%b/cnt%0d exp=pop1/cnt3", pop_o, fifo_count_o); end
    wait_got(gb + 6, 40);
    cycles(2);
    total++; if (got.size() - gb !== 6) begin bad++; $display("FAIL full_n got=%0d exp=6", got.size() - gb); end
    for (int i = 0; i < 6 && gb + i < got.size(); i++) begin
      total++; if (got[gb+i] !== pkt(8'h12, 16'h0200 + 16'(i))) begin
        bad++; $display("FAIL full_data[%0d] got=%h exp=%h", i, got[gb+i], pkt(8'h12, 16'h0200 + 16'(i))); end
    end
    total++; if (rx_count_o !== 16'd6) begin bad++; $display("FAIL full_rx got=%0d exp=6", rx_count_o); end
  endtask

  task automatic test_reset_in_settle();
    int gb, k;
    do_reset();
    rd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push(pkt(8'h12, 16'h0300 + 16'(i)));
    k = 0;
    cycles(1);
    while (pop_o !== 1'b1 && k < 10) begin cycles(1); k++; end
    total++; if (pop_o !== 1'b1) begin bad++; $display("FAIL settle_reach got=%b exp=1", pop_o); end
    rst_ni = 1'b0;
    #1;
    total++; if (pop_o !== 1'b0) begin bad++; $display("FAIL settle_abort got=%b exp=0", pop_o); end
    total++; if (fifo_count_o !== 3'd0 || rd_valid_o !== 1'b0) begin
      bad++; $display("FAIL settle_fifo got=cnt%0d/v%b exp=cnt0/v0", fifo_count_o, rd_valid_o); end
    total++; if (rx_count_o !== 16'd0) begin bad++; $display("FAIL settle_rx got=%0d exp=0", rx_count_o); end
    gb = got.size();
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_got(gb + 3, 30);
    cycles(2);
    total++; if (got.size() - gb !== 3) begin bad++; $display("FAIL settle_n got=%0d exp=3", got.size() - gb); end
    for (int i = 0; i < 3 && gb + i < got.size(); i++) begin
      total++; if (got[gb+i] !== pkt(8'h12, 16'h0300 + 16'(i))) begin
        bad++; $display("FAIL settle_data[%0d] got=%h exp=%h", i, got[gb+i], pkt(8'h12, 16'h0300 + 16'(i))); end
    end
  endtask

  task automatic test_back_to_back();
    total++; if (dbl_pop !== 0) begin bad++; $display("FAIL double_pop got=%0d exp=0", dbl_pop); end
  endtask

`ifdef MESH_TERM_RX_TIMESTAMP_EN
  task automatic test_timestamp();
    logic [31:0] t0, t1;
    do_reset();
    push(pkt(8'h12, 16'h0400));
    push(pkt(8'h12, 16'h0401));
    cycles(10);
    t0 = rd_ts_o;
    rd_ready_i = 1'b1;
    cycles(1);
    rd_ready_i = 1'b0;
    t1 = rd_ts_o;
    total++; if (t1 - t0 !== 32'd2) begin bad++; $display("FAIL ts_delta got=%0d exp=2", t1 - t0); end
    total++; if (rd_data_o !== pkt(8'h12, 16'h0401)) begin
      bad++; $display("FAIL ts_data got=%h exp=%h", rd_data_o, pkt(8'h12, 16'h0401)); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_misroute();
    test_broadcast();
    test_full();
    test_reset_in_settle();
`ifdef MESH_TERM_RX_TIMESTAMP_EN
    test_timestamp();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mesh_term_rx.md
MESH_TERM_RX -- requirements
Module: mesh_term_rx

Interface
REQ-001 Parameter PAKG_SIZE, default 32: packet width in bits; minimum 16.
REQ-002 Parameter DEPTH, default 4: local receive FIFO entries; power of two, at least 2.
REQ-003 Parameter ROW_ID, default 0: 4-bit row address of this terminal.
REQ-004 Parameter COL_ID, default 0: 4-bit column address of this terminal.
REQ-005 Parameter BDCST, default 8'hFF: broadcast ID value.
REQ-006 Port clk_i, in, 1 bit: single clock; all state updates on the rising edge.
REQ-007 Port rst_ni, in, 1 bit: asynchronous, active-low reset.
REQ-008 Port pndng_i, in, 1 bit: mesh terminal output holds a packet.
REQ-009 Port data_out_i, in, PAKG_SIZE bits: mesh terminal head packet.
REQ-010 Port pop_o, out, 1 bit: one-cycle pop pulse to the mesh terminal.
REQ-011 Port rd_valid_o, out, 1 bit: local FIFO non-empty.
REQ-012 Port rd_data_o, out, PAKG_SIZE bits: local FIFO head packet.
REQ-013 Port rd_ready_i, in, 1 bit: consumer accepts the head packet.
REQ-014 Port fifo_count_o, out, $clog2(DEPTH)+1 bits: current occupancy.
REQ-015 Port rx_count_o, out, 16 bits: accepted packets, saturating.
REQ-016 Port misroute_count_o, out, 16 bits: dropped misaddressed packets, saturating.

Function
REQ-017 ID field = data_out_i[PAKG_SIZE-9 -: 8], split as {row[7:4], col[3:0]}; packet matches if ID == {ROW_ID,COL_ID} or ID == BDCST.
REQ-018 FSM states: IDLE and SETTLE only.
REQ-019 IDLE -> SETTLE transition at the edge where pndng_i=1 and fifo_count_o<DEPTH: pop_o<=1, data_out_i is sampled; otherwise stays in IDLE with pop_o<=0.
REQ-020 SETTLE -> IDLE unconditionally next edge with pop_o<=0; pop_o is never high two consecutive cycles; peak rate is 1 packet per 2 cycles.
REQ-021 Sampled matching packet is written to the FIFO tail at the same edge; rx_count_o increments.
REQ-022 Sampled non-matching packet is dropped; misroute_count_o increments; pop_o is still issued.
REQ-023 FIFO full (count==DEPTH): IDLE holds, pop_o stays 0 regardless of pndng_i; a same-cycle read does not unblock that edge.
REQ-024 Read: rd_valid_o = (count!=0); rd_data_o = head combinationally; head advances at the edge where rd_valid_o && rd_ready_i.
REQ-025 rd_ready_i with empty FIFO is ignored.
REQ-026 Write and read on the same edge leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 Counters saturate at 16'hFFFF and do not wrap.

Reset
REQ-028 rst_ni=0 immediately forces: FSM=IDLE, pop_o=0, FIFO pointers and count=0, rd_valid_o=0, rx_count_o=0, misroute_count_o=0.
REQ-029 Reset asserted in SETTLE aborts that cycle's pop_o pulse; any partially received packet is lost.
REQ-030 First pop_o is possible at the second rising edge after rst_ni deasserts.

Configuration
REQ-031 Macro MESH_TERM_RX_TIMESTAMP_EN defined: a 32-bit free-running cycle counter is added, cleared by reset; its value at the accepting IDLE->SETTLE edge is stored alongside each FIFO entry and presented on an extra port, rd_ts_o (out, 32 bits), aligned with rd_data_o.
REQ-032 Macro undefined: the counter, the per-entry storage and the rd_ts_o port do not exist.

Verification
REQ-033 ROW_ID=1, COL_ID=2; pndng_i held 1 with ID 8'h12 for 6 packets, rd_ready_i=1 -> pop_o pulses every 2nd cycle; 6 packets out in order; rx_count_o=6.
REQ-034 ID 8'h33 at a (1,2) terminal -> one pop_o pulse; rd_valid_o stays 0; misroute_count_o=1.
REQ-035 ID 8'hFF -> accepted; rx_count_o=1.
REQ-036 DEPTH=4, rd_ready_i=0, 6 matching packets pending -> exactly 4 pops, then pop_o=0 and fifo_count_o=4; rd_ready_i=1 -> pops resume; all 6 delivered in order.
REQ-037 rst_ni pulled low during the SETTLE cycle -> pop_o=0 in the same cycle; all counts=0; after release, normal pops resume.
REQ-038 With MESH_TERM_RX_TIMESTAMP_EN: 2 back-to-back accepted packets -> rd_ts_o values differ by exactly 2.
